switch_debounce_sync: RTL and testbench

- Conditions raw board slide-switch inputs before they reach the switch PIO's `in_port` (8-bit, read at address 0).
- Per bit: metastability synchronizer, then a consecutive-stable-cycle debounce filter.
- Outputs a clean level bus to the PIO, plus one-cycle rise/fall strobes and an any-change strobe for software or an edge-capture stage.
- Sits between the top-level switch pins and the PIO, in the clk domain.

---
 rtl/switch_pkg.sv | 14 +
 rtl/debounce_bit.sv | 56 +++++
 rtl/switch_debounce_sync.sv | 41 ++++
 tb/tb_switch_debounce_sync.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants and helpers for the slide-switch conditioning path.
package switch_pkg;

  localparam int unsigned SW_WIDTH            = 8;
  localparam int unsigned DEBOUNCE_10MS_50MHZ = 500000;

  // Width of a counter that must reach cycles-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    int unsigned w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer chain, consecutive-stable-cycle filter, edge strobes.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic update_c
);

  localparam int unsigned      CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync;
  logic                   differ;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], sw_raw};
  end

  assign sync     = sync_q[SYNC_STAGES-1];
  assign differ   = sync ^ sw_clean;
  assign update_c = differ && (cnt_q == CNT_MAX);

  // Any agreement with the clean level, or a completed count, restarts the run.
  always_comb begin
    cnt_d = '0;
    if (differ && !update_c) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      sw_clean   <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      if (update_c) sw_clean <= sync;
      rise_pulse <= update_c & sync;
      fall_pulse <= update_c & ~sync;
    end
  end

endmodule

// File: rtl/switch_debounce_sync.sv
// Debounced, synchronized slide-switch bus for the switch PIO, with edge strobes.
module switch_debounce_sync
  import switch_pkg::*;
#(
  parameter int unsigned WIDTH           = SW_WIDTH,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_10MS_50MHZ
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  logic [WIDTH-1:0] update_c;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw    (sw_raw[i]),
      .sw_clean  (sw_clean[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .update_c  (update_c[i])
    );
  end

  // Registered from the same update terms, so it lines up with the strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) changed <= 1'b0;
    else          changed <= |update_c;
  end

endmodule

// File: tb/tb_switch_debounce_sync.sv
// Self-checking bench for switch_debounce_sync with a sliding-window reference model.
module tb_switch_debounce_sync;

  localparam int unsigned W  = 8;
  localparam int unsigned S  = 2;
  localparam int unsigned D  = 4;
  localparam int unsigned HD = S + D - 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] sw_raw = '0;
  logic [W-1:0] sw_clean, rise_pulse, fall_pulse;
  logic         changed;

  int checks = 0;
  int errors = 0;

  switch_debounce_sync #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw),
    .sw_clean(sw_clean), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .changed(changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: a bit flips once the raw samples seen through the synchronizer over
  // the last D edges all disagree with its clean level.
  logic [W-1:0] hist [HD];
  logic [W-1:0] m_clean, m_rise, m_fall;
  logic         m_changed;

  always @(posedge clk or negedge reset_n) begin
    logic [W-1:0] nxt;
    logic         all_diff;
    if (!reset_n) begin
      for (int j = 0; j < int'(HD); j++) hist[j] = '0;
      m_clean = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
    end else begin
      for (int i = 0; i < int'(W); i++) begin
        all_diff = 1'b1;
        for (int j = 0; j < int'(D); j++)
          if (hist[S-1+j][i] == m_clean[i]) all_diff = 1'b0;
        nxt[i] = all_diff ? ~m_clean[i] : m_clean[i];
      end
      m_rise    = nxt & ~m_clean;
      m_fall    = ~nxt & m_clean;
      m_changed = |(m_rise | m_fall);
      m_clean   = nxt;
      for (int j = int'(HD) - 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = sw_raw;
    end
  end

  always @(negedge clk) begin
    chk("model_sw_clean", 32'(sw_clean), 32'(m_clean));
    chk("model_rise", 32'(rise_pulse), 32'(m_rise));
    chk("model_fall", 32'(fall_pulse), 32'(m_fall));
    chk("model_changed", 32'(changed), 32'(m_changed));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [W-1:0] r;
    int run [W];

    // Reset state and quiet idle.
    tick(3);
    chk("reset_clean", 32'(sw_clean), 32'h0);
    chk("reset_strobes", 32'({rise_pulse, fall_pulse, 7'b0, changed}), 32'h0);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk("idle_outputs", 32'({sw_clean, rise_pulse, fall_pulse, changed}), 32'h0);
    end

    // Single clean step on bit 0.
    sw_raw = 8'h01;
    tick(5);
    chk("step_before_clean", 32'(sw_clean), 32'h00);
    tick();
    chk("step_clean", 32'(sw_clean), 32'h01);
    chk("step_rise", 32'(rise_pulse), 32'h01);
    chk("step_changed", 32'(changed), 32'h1);
    tick();
    chk("step_rise_gone", 32'(rise_pulse), 32'h00);
    chk("step_changed_gone", 32'(changed), 32'h0);

    // Return to zero, then bounce bit 3 with runs one cycle too short.
    sw_raw = 8'h00;
    tick(10);
    chk("settle_zero", 32'(sw_clean), 32'h00);
    for (int k = 0; k < 5; k++) begin
      sw_raw = 8'h08;
      for (int c = 0; c < 3; c++) begin
        tick();
        chk("bounce_outputs", 32'({sw_clean, rise_pulse, fall_pulse, changed}), 32'h0);
      end
      sw_raw = 8'h00;
      tick();
      chk("bounce_outputs", 32'({sw_clean, rise_pulse, fall_pulse, changed}), 32'h0);
    end
    tick(6);
    chk("bounce_final", 32'(sw_clean), 32'h00);

    // Upper nibble falls together.
    sw_raw = 8'hFF;
    tick(10);
    chk("all_high", 32'(sw_clean), 32'hFF);
    sw_raw = 8'h0F;
    tick(5);
    chk("fall_before", 32'(sw_clean), 32'hFF);
    tick();
    chk("fall_clean", 32'(sw_clean), 32'h0F);
    chk("fall_pulse", 32'(fall_pulse), 32'hF0);
    chk("fall_no_rise", 32'(rise_pulse), 32'h00);
    chk("fall_changed", 32'(changed), 32'h1);
    tick();
    chk("fall_pulse_gone", 32'(fall_pulse), 32'h00);
    chk("fall_changed_gone", 32'(changed), 32'h0);

    // Reset in the middle of a pending count on bit 7.
    tick(4);
    sw_raw = 8'h80;
    tick(2);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset_clean", 32'(sw_clean), 32'h00);
    chk("midreset_strobes", 32'({rise_pulse, fall_pulse, 7'b0, changed}), 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    chk("post_reset_before", 32'(sw_clean), 32'h00);
    tick();
    chk("post_reset_clean", 32'(sw_clean), 32'h80);
    chk("post_reset_rise", 32'(rise_pulse), 32'h80);
    chk("post_reset_changed", 32'(changed), 32'h1);
    tick();
    chk("post_reset_rise_gone", 32'(rise_pulse), 32'h00);

    // Random bounce runs of 1..6 cycles per bit; the model checks every cycle.
    r = sw_raw;
    for (int i = 0; i < int'(W); i++) run[i] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (run[i] == 0) begin
          r[i] = ~r[i];
          run[i] = int'($urandom_range(1, 6));
        end
        run[i]--;
      end
      sw_raw = r;
      tick();
    end
    tick(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
